fmap_serializer: RTL and testbench

//  Reads a flat channel-major feature-map vector, as produced by the

---
 rtl/fmap_serializer_pkg.sv | 21 ++
 rtl/fmap_serializer_if.sv | 37 +++
 rtl/fmap_serializer_idx_counter.sv | 74 +++++++
 rtl/fmap_serializer.sv | 100 ++++++++++
 tb/tb_fmap_serializer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_serializer_pkg.sv
// Shared state type and index helpers for the feature-map serializer and deserializer.
// Both blocks use the same channel-major flat layout.
package fmap_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

    // Width of an index into n items; at least one bit so that size-1 dimensions stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of element (c, y, x) in the flat channel-major vector.
    function automatic int elem_off(input int c, input int y, input int x,
                                    input int h, input int w, input int width);
        return ((c * h + y) * w + x) * width;
    endfunction

endpackage

// File: rtl/fmap_serializer_if.sv
// Tensor-in / beat-out bus of fmap_serializer.
// Handshake: a transfer happens on a clock edge where valid && ready. The sender holds valid and its
// payload stable until that edge. For in_*, the serializer is the receiver; for out_*, it is the sender.
interface fmap_serializer_if #(
    parameter int CH    = 1,
    parameter int H     = 1,
    parameter int W     = 1,
    parameter int WIDTH = 16,
    parameter int LANES = 1
);
    localparam int CW = fmap_pkg::idx_w(CH);
    localparam int YW = fmap_pkg::idx_w(H);
    localparam int XW = fmap_pkg::idx_w(W);

    logic [CH*H*W*WIDTH-1:0] in_vec;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*WIDTH-1:0]  out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW-1:0]           out_ch;
    logic [YW-1:0]           out_y;
    logic [XW-1:0]           out_x;
    logic                    out_last;
    logic                    busy;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch, out_y, out_x, out_last, busy
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch, out_y, out_x, out_last, busy
    );

endinterface

// File: rtl/fmap_serializer_idx_counter.sv
// Nested x/y/ch beat counter: x steps by LANES and wraps into y, and y wraps into ch.
// last_o flags the final beat of the tensor.
module fmap_idx_counter
    import fmap_pkg::*;
#(
    parameter int CH    = 1,
    parameter int H     = 1,
    parameter int W     = 1,
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   advance_i,
    output logic [idx_w(CH)-1:0]   ch_o,
    output logic [idx_w(H)-1:0]    y_o,
    output logic [idx_w(W)-1:0]    x_o,
    output logic                   last_o
);
    localparam int CW = idx_w(CH);
    localparam int YW = idx_w(H);
    localparam int XW = idx_w(W);

    logic [CW-1:0] ch_q, ch_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x_q, x_d;
    logic          x_wrap, y_wrap, ch_wrap;

    assign x_wrap  = (int'(x_q) + LANES == W);
    assign y_wrap  = (int'(y_q) == H - 1);
    assign ch_wrap = (int'(ch_q) == CH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
            y_q  <= '0;
            x_q  <= '0;
        end else begin
            ch_q <= ch_d;
            y_q  <= y_d;
            x_q  <= x_d;
        end
    end

    // clear has priority: a tensor accepted on the last beat restarts at (0,0,0).
    always_comb begin
        ch_d = ch_q;
        y_d  = y_q;
        x_d  = x_q;
        if (clear_i) begin
            ch_d = '0;
            y_d  = '0;
            x_d  = '0;
        end else if (advance_i) begin
            if (x_wrap) begin
                x_d = '0;
                if (y_wrap) begin
                    y_d  = '0;
                    ch_d = ch_wrap ? '0 : ch_q + CW'(1);
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(LANES);
            end
        end
    end

    assign ch_o   = ch_q;
    assign y_o    = y_q;
    assign x_o    = x_q;
    assign last_o = x_wrap && y_wrap && ch_wrap;

endmodule

// File: rtl/fmap_serializer.sv
// Captures a flat channel-major feature map and streams it LANES elements per beat,
// tagging each beat with its (ch, y, x) position.
module fmap_serializer
    import fmap_pkg::*;
#(
    parameter int CH    = 1,
    parameter int H     = 1,
    parameter int W     = 1,
    parameter int WIDTH = 16,
    parameter int LANES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fmap_serializer_if.slave    bus,
    output ser_state_t          dbg_state_o
);
    localparam int TOT = CH * H * W * WIDTH;
    localparam int CW  = idx_w(CH);
    localparam int YW  = idx_w(H);
    localparam int XW  = idx_w(W);

    if (W % LANES != 0) begin : g_lane_check
        $error("fmap_serializer: W must be a multiple of LANES");
    end

    ser_state_t    state_q, state_d;
    logic [TOT-1:0] buf_q;
    logic [CW-1:0] cnt_ch;
    logic [YW-1:0] cnt_y;
    logic [XW-1:0] cnt_x;
    logic          cnt_last;
    logic          stream, beat_hs, in_rdy, accept;

    assign stream  = (state_q == STREAM);
    assign beat_hs = stream && bus.out_ready;
    // A new tensor may overlap the final beat of the previous one, so streams run back to back.
    assign in_rdy  = !stream || (beat_hs && cnt_last);
    assign accept  = bus.in_valid && in_rdy;

    fmap_idx_counter #(
        .CH    (CH),
        .H     (H),
        .W     (W),
        .LANES (LANES)
    ) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (accept),
        .advance_i (beat_hs),
        .ch_o      (cnt_ch),
        .y_o       (cnt_y),
        .x_o       (cnt_x),
        .last_o    (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (accept) begin
            buf_q <= bus.in_vec;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = STREAM;
            STREAM:  if (beat_hs && cnt_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = in_rdy;
        bus.out_valid = stream;
        bus.busy      = stream;
        bus.out_last  = stream && cnt_last;
        bus.out_ch    = cnt_ch;
        bus.out_y     = cnt_y;
        bus.out_x     = cnt_x;
        dbg_state_o   = state_q;
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.out_data[i*WIDTH +: WIDTH] =
                WIDTH'(buf_q >> elem_off(int'(cnt_ch), int'(cnt_y), int'(cnt_x) + i, H, W, WIDTH));
        end
    end

endmodule

// File: tb/tb_fmap_serializer.sv
// Bench for fmap_serializer: a 2x2x4 map with 2 lanes, plus a 1x1x1 single-lane instance.
// Expected beats are queued when a tensor is offered and checked on each output handshake.
`timescale 1ns/1ps
module tb_fmap_serializer;
    import fmap_pkg::*;

    localparam int CH    = 2;
    localparam int H     = 2;
    localparam int W     = 4;
    localparam int WIDTH = 16;
    localparam int LANES = 2;
    localparam int N     = CH * H * W;
    localparam int EW    = 1 + 1 + 1 + 2 + LANES * WIDTH;
    localparam int EW1   = 1 + 1 + 1 + 1 + WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fmap_serializer_if #(.CH(CH), .H(H), .W(W), .WIDTH(WIDTH), .LANES(LANES)) bus ();
    fmap_serializer_if #(.CH(1), .H(1), .W(1), .WIDTH(WIDTH), .LANES(1)) bus1 ();
    ser_state_t st, st1;

    fmap_serializer #(.CH(CH), .H(H), .W(W), .WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (st)
    );

    fmap_serializer #(.CH(1), .H(1), .W(1), .WIDTH(WIDTH), .LANES(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus1),
        .dbg_state_o (st1)
    );

    logic [EW-1:0]  exp_q[$];
    logic [EW1-1:0] exp1_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int beats_seen = 0;
    logic [EW-1:0]  mon_got, mon_exp;
    logic [EW1-1:0] mon1_got, mon1_exp;

    function automatic logic [N*WIDTH-1:0] make_vec(input int base);
        logic [N*WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(base + i);
        return v;
    endfunction

    function automatic logic [EW-1:0] cur_beat();
        return {bus.out_last, bus.out_ch, bus.out_y, bus.out_x, bus.out_data};
    endfunction

    // Beat k covers flat elements 2k and 2k+1: ch = k/4, y = (k/2)%2, x = 2*(k%2).
    task automatic push_tensor(input int base);
        int lo;
        for (int k = 0; k < N / LANES; k++) begin
            lo = base + 2 * k;
            exp_q.push_back({1'(k == N / LANES - 1), 1'(k / 4), 1'((k / 2) % 2), 2'((k % 2) * LANES),
                             16'(lo + 1), 16'(lo)});
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the next negedge after acceptance.
    task automatic send_tensor(input int base);
        bus.in_vec   = make_vec(base);
        bus.in_valid = 1'b1;
        push_tensor(base);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at negedge+1; cycles = -1 if the queue did not empty within budget.
    task automatic wait_drain(input int budget, output int cycles);
        cycles = 0;
        #2;
        while (exp_q.size() != 0 && cycles < budget) begin
            @(negedge clk);
            #3;
            cycles++;
        end
        if (exp_q.size() != 0) cycles = -1;
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            beats_seen++;
            n_checks++;
            mon_got = cur_beat();
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL beat_unexpected: got %h, required no beat", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_errors++;
                    $display("FAIL beat_content {last,ch,y,x,data}: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            n_checks++;
            mon1_got = {bus1.out_last, bus1.out_ch, bus1.out_y, bus1.out_x, bus1.out_data};
            if (exp1_q.size() == 0) begin
                n_errors++;
                $display("FAIL deg_beat_unexpected: got %h, required no beat", mon1_got);
            end else begin
                mon1_exp = exp1_q.pop_front();
                if (mon1_got !== mon1_exp) begin
                    n_errors++;
                    $display("FAIL deg_beat_content: got %h, required %h", mon1_got, mon1_exp);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready, bus.out_last} !== 4'b0010) begin
            n_errors++;
            $display("FAIL reset_flags {valid,busy,in_ready,last}: got %b, required 0010",
                     {bus.out_valid, bus.busy, bus.in_ready, bus.out_last});
        end
        n_checks++;
        if (st !== IDLE || bus.out_data !== '0) begin
            n_errors++;
            $display("FAIL reset_state_data: got state %0d data %h, required state 0 data 0", st, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus1.out_valid, bus1.in_ready} !== 4'b0101) begin
            n_errors++;
            $display("FAIL reset_release_idle: got %b, required 0101",
                     {bus.out_valid, bus.in_ready, bus1.out_valid, bus1.in_ready});
        end
    endtask

    task automatic test_basic();
        int cyc;
        @(negedge clk);
        bus.out_ready = 1'b1;
        send_tensor(0);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.out_ch, bus.out_y, bus.out_x} !== 6'b110000) begin
            n_errors++;
            $display("FAIL basic_first_beat {valid,busy,ch,y,x}: got %b, required 110000",
                     {bus.out_valid, bus.busy, bus.out_ch, bus.out_y, bus.out_x});
        end
        wait_drain(20, cyc);
        n_checks++;
        if (cyc != 7) begin
            n_errors++;
            $display("FAIL basic_consecutive: got %0d extra cycles, required 7", cyc);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001 || st !== IDLE) begin
            n_errors++;
            $display("FAIL basic_back_to_idle {valid,busy,in_ready}: got %b, required 001",
                     {bus.out_valid, bus.busy, bus.in_ready});
        end
    endtask

    task automatic test_backpressure();
        int cycles, start;
        logic phase, stalled;
        logic [EW-1:0] held;
        @(negedge clk);
        bus.out_ready = 1'b0;
        start = beats_seen;
        send_tensor(0);
        phase = 1'b1;
        stalled = 1'b0;
        held = '0;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 40) begin
            bus.out_ready = phase;
            phase = !phase;
            #1;
            if (stalled) begin
                n_checks++;
                if ({bus.out_valid, cur_beat()} !== {1'b1, held}) begin
                    n_errors++;
                    $display("FAIL stall_hold: got %h, required %h", {bus.out_valid, cur_beat()}, {1'b1, held});
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = cur_beat();
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0 || beats_seen - start != 8) begin
            n_errors++;
            $display("FAIL backpressure_count: got %0d beats with %0d pending, required 8 with 0",
                     beats_seen - start, exp_q.size());
            exp_q.delete();
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cycles, cyc;
        @(negedge clk);
        bus.out_ready = 1'b1;
        send_tensor(0);
        cycles = 0;
        while (!(bus.out_valid && bus.out_last) && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (!(bus.out_valid && bus.out_last)) begin
            n_errors++;
            $display("FAIL b2b_last_seen: got no last beat, required one within 20 cycles");
        end
        bus.in_vec   = make_vec(100);
        bus.in_valid = 1'b1;
        push_tensor(100);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_in_ready: got %b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_ch, bus.out_y, bus.out_x, bus.out_data} !== {1'b1, 4'b0000, 16'd101, 16'd100}) begin
            n_errors++;
            $display("FAIL b2b_no_bubble: got %h, required %h",
                     {bus.out_valid, bus.out_ch, bus.out_y, bus.out_x, bus.out_data},
                     {1'b1, 4'b0000, 16'd101, 16'd100});
        end
        wait_drain(20, cyc);
        n_checks++;
        if (cyc != 7) begin
            n_errors++;
            $display("FAIL b2b_drain: got %0d extra cycles, required 7", cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_isolation();
        int cycles;
        @(negedge clk);
        bus.out_ready = 1'b1;
        send_tensor(200);
        bus.in_vec = '1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 80) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL isolation_drain: got %0d pending beats, required 0", exp_q.size());
            exp_q.delete();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cycles, start, cyc;
        @(negedge clk);
        bus.out_ready = 1'b1;
        start = beats_seen;
        send_tensor(0);
        cycles = 0;
        #3;
        while (beats_seen - start < 4 && cycles < 20) begin
            @(negedge clk);
            #3;
            cycles++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready, bus.out_last} !== 4'b0010 || st !== IDLE) begin
            n_errors++;
            $display("FAIL reset_mid_idle {valid,busy,in_ready,last}: got %b, required 0010",
                     {bus.out_valid, bus.busy, bus.in_ready, bus.out_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_tensor(50);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_ch, bus.out_y, bus.out_x, bus.out_data} !== {1'b1, 4'b0000, 16'd51, 16'd50}) begin
            n_errors++;
            $display("FAIL reset_mid_restart: got %h, required %h",
                     {bus.out_valid, bus.out_ch, bus.out_y, bus.out_x, bus.out_data},
                     {1'b1, 4'b0000, 16'd51, 16'd50});
        end
        wait_drain(20, cyc);
        n_checks++;
        if (cyc != 7) begin
            n_errors++;
            $display("FAIL reset_mid_drain: got %0d extra cycles, required 7", cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_degenerate();
        @(negedge clk);
        bus1.out_ready = 1'b1;
        bus1.in_vec    = 16'h1234;
        bus1.in_valid  = 1'b1;
        exp1_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 16'h1234});
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.in_vec   = 16'hFFFF;
        #1;
        n_checks++;
        if ({bus1.out_valid, bus1.out_last, bus1.in_ready, bus1.out_data} !== {3'b111, 16'h1234}) begin
            n_errors++;
            $display("FAIL deg_single_beat {valid,last,in_ready,data}: got %h, required %h",
                     {bus1.out_valid, bus1.out_last, bus1.in_ready, bus1.out_data}, {3'b111, 16'h1234});
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (exp1_q.size() != 0 || bus1.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL deg_one_beat_only: got valid %b pending %0d, required 0 and 0",
                     bus1.out_valid, exp1_q.size());
        end
    endtask

    initial begin
        bus.in_vec     = '0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_vec    = '0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_isolation();
        test_reset_mid();
        test_degenerate();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got %0d/%0d pending, required 0/0", exp_q.size(), exp1_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
